dac_ltc2624_spi_ctrl: RTL

DAC_LTC2624_SPI_CTRL -- requirements
Module: dac_ltc2624_spi_ctrl

---
 rtl/dac_ltc2624_spi_ctrl.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/dac_ltc2624_spi_ctrl.sv
// SPI master for the LTC2624 quad DAC: sends one 32-bit frame per accepted start and
// captures the 32 bits returned on SDO. SCK/MOSI/CS are registered decodes of the next state.
module dac_ltc2624_spi_ctrl #(
  parameter int unsigned CLK_DIV = 2,
  parameter int unsigned GAP     = 4
) (
  input  logic        clk,
  input  logic        DAC_CLR,
  input  logic        start,
  input  logic [3:0]  cmd,
  input  logic [3:0]  addr,
  input  logic [11:0] data,
  input  logic        DAC_OUT,
  output logic        SPI_SCK,
  output logic        SPI_MOSI,
  output logic        DAC_CS,
  output logic        busy,
  output logic        done,
  output logic [31:0] rx_word
);

  typedef enum logic [2:0] {StIdle, StSetup, StSckHi, StSckLo, StGap} state_e;

  localparam logic [7:0] DivLast = 8'(CLK_DIV - 1);
  localparam logic [7:0] GapLast = 8'(GAP - 1);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [4:0]  bit_q, bit_d;
  logic [1:0]  rdy_q;
  logic [31:0] tx_q, tx_d, rx_sh_q, rx_sh_d, rx_word_q, rx_word_d;
  logic        sck_q, sck_d, cs_q, cs_d, busy_q, busy_d, done_q, done_d;
  logic        div_end, accept;

  assign div_end = (cnt_q == DivLast);
  // Reset release is synchronised: start is honoured only once rdy_q has filled.
  assign accept  = start & rdy_q[1];

  always_ff @(posedge clk or negedge DAC_CLR) begin
    if (!DAC_CLR) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      bit_q   <= '0;
      rdy_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      rdy_q   <= {rdy_q[0], 1'b1};
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 8'd1;
    bit_d   = bit_q;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (accept) begin
          state_d = StSetup;
          bit_d   = '0;
        end
      end
      StSetup: begin
        if (div_end) begin
          state_d = StSckHi;
          cnt_d   = '0;
        end
      end
      StSckHi: begin
        if (div_end) begin
          state_d = StSckLo;
          cnt_d   = '0;
        end
      end
      StSckLo: begin
        if (div_end) begin
          cnt_d = '0;
          if (bit_q == 5'd31) begin
            state_d = StGap;
          end else begin
            state_d = StSckHi;
            bit_d   = bit_q + 5'd1;
          end
        end
      end
      StGap: begin
        if (cnt_q == GapLast) begin
          state_d = StIdle;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    sck_d     = (state_d == StSckHi);
    cs_d      = !(state_d inside {StSetup, StSckHi, StSckLo});
    busy_d    = (state_d != StIdle);
    done_d    = (state_d == StGap) && (state_q != StGap);
    tx_d      = tx_q;
    rx_sh_d   = rx_sh_q;
    rx_word_d = rx_word_q;
    if (state_q == StIdle && state_d == StSetup) begin
      tx_d = {8'h00, cmd, addr, data, 4'h0};
    end
    // MOSI only moves on the falling SCK edge.
    if (state_d == StSckLo && state_q != StSckLo) begin
      tx_d = {tx_q[30:0], 1'b0};
    end
    if (state_d == StSckHi && state_q != StSckHi) begin
      rx_sh_d = {rx_sh_q[30:0], DAC_OUT};
    end
    if (done_d) begin
      tx_d      = '0;
      rx_word_d = rx_sh_q;
    end
  end

  always_ff @(posedge clk or negedge DAC_CLR) begin
    if (!DAC_CLR) begin
      sck_q     <= 1'b0;
      cs_q      <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      tx_q      <= '0;
      rx_sh_q   <= '0;
      rx_word_q <= '0;
    end else begin
      sck_q     <= sck_d;
      cs_q      <= cs_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      tx_q      <= tx_d;
      rx_sh_q   <= rx_sh_d;
      rx_word_q <= rx_word_d;
    end
  end

  assign SPI_SCK  = sck_q;
  assign SPI_MOSI = tx_q[31];
  assign DAC_CS   = cs_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign rx_word  = rx_word_q;

endmodule
